// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: word/address widths and the buffered-store entry
// layout. Used by the store buffer and the memory controller.
package mem_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned WADDR_W = 15;

  // One buffered store: word address (byte address bits [15:1]) and data.
  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [WORD_W-1:0]  data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store buffer bus: retire-side enqueue handshake, drain port towards the memory controller
// write port 0, and the two load-forwarding ports.
//   slave  : the store buffer side (accepts stores, drives writes and forwarding results)
//   master : the environment side (retire stage, memory controller, load pipes)
interface store_buffer_if #(
  parameter int unsigned DEPTH = 8
) ();
  import mem_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic               enq_valid;
  logic [WADDR_W-1:0] enq_addr;
  logic [WORD_W-1:0]  enq_data;
  logic               enq_ready;

  logic               mem_ready;
  logic               wen0;
  logic [WADDR_W-1:0] waddr0;
  logic [WORD_W-1:0]  wdata0;

  logic [WADDR_W-1:0] fwd_addr0;
  logic               fwd_hit0;
  logic [WORD_W-1:0]  fwd_data0;
  logic [WADDR_W-1:0] fwd_addr1;
  logic               fwd_hit1;
  logic [WORD_W-1:0]  fwd_data1;

  logic [CNT_W-1:0]   count;

  modport slave (
    input  enq_valid, enq_addr, enq_data, mem_ready, fwd_addr0, fwd_addr1,
    output enq_ready, wen0, waddr0, wdata0, fwd_hit0, fwd_data0, fwd_hit1, fwd_data1, count
  );

  modport master (
    output enq_valid, enq_addr, enq_data, mem_ready, fwd_addr0, fwd_addr1,
    input  enq_ready, wen0, waddr0, wdata0, fwd_hit0, fwd_data0, fwd_hit1, fwd_data1, count
  );

endinterface

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding lookup for one read port.
// Ports:
//   i_entries : all buffer slots {addr, data}
//   i_valid   : per-slot valid bits
//   i_tail    : next free slot; slots are visited from tail onwards, i.e. oldest to youngest
//   i_addr    : load word address
//   o_hit     : some valid slot holds i_addr
//   o_data    : data of the youngest matching slot, 0 on miss
module sb_fwd_match
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  sb_entry_t [DEPTH-1:0]         i_entries,
  input  logic [DEPTH-1:0]              i_valid,
  input  logic [$clog2(DEPTH)-1:0]      i_tail,
  input  logic [WADDR_W-1:0]            i_addr,
  output logic                          o_hit,
  output logic [WORD_W-1:0]             o_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] w_idx;

  // Rotating by tail walks slots oldest-first (invalid slots are skipped), so a later match
  // overrides an earlier one and the youngest store wins even across the pointer wrap.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = i_tail + PTR_W'(k);
      if (i_valid[w_idx] && (i_entries[w_idx].addr == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Age-ordered buffer of committed stores in front of the memory controller write port 0.
// Drains at most one store per cycle in program order and forwards buffered data to two
// independent load ports.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; empties the buffer, wins over enq/pop
//   bus   : store_buffer_if.slave (enqueue, drain, forwarding, occupancy)
module store_buffer
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  sb_entry_t [DEPTH-1:0] r_entries;
  logic [DEPTH-1:0]      r_valid;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  w_ready;
  logic                  w_nonempty;
  logic                  w_push;
  logic                  w_pop;
  sb_entry_t             w_head;
  logic [ADDR_W-1:0]     w_head_addr;
  logic [DATA_W-1:0]     w_head_data;

  // Readiness depends only on registered occupancy; a pop in the same cycle does not free a
  // slot for the incoming store.
  assign w_ready    = (r_count != FULL_CNT);
  assign w_nonempty = (r_count != '0);
  assign w_push     = bus.enq_valid && w_ready;
  assign w_pop      = w_nonempty && bus.mem_ready;

  assign w_head      = r_entries[r_head];
  assign w_head_addr = w_nonempty ? w_head.addr : '0;
  assign w_head_data = w_nonempty ? w_head.data : '0;

  assign bus.enq_ready = w_ready;
  assign bus.wen0      = w_pop;
  assign bus.waddr0    = w_head_addr;
  assign bus.wdata0    = w_head_data;
  assign bus.count     = r_count;

  // Control state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: every read is qualified by a valid bit or the count.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_entries[r_tail] <= '{addr: bus.enq_addr, data: bus.enq_data};
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd0 (
    .i_entries (r_entries),
    .i_valid   (r_valid),
    .i_tail    (r_tail),
    .i_addr    (bus.fwd_addr0),
    .o_hit     (bus.fwd_hit0),
    .o_data    (bus.fwd_data0)
  );

  sb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd1 (
    .i_entries (r_entries),
    .i_valid   (r_valid),
    .i_tail    (r_tail),
    .i_addr    (bus.fwd_addr1),
    .o_hit     (bus.fwd_hit1),
    .o_data    (bus.fwd_data1)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a directed vector table, hand-written multi-cycle
// sequences (full, wrap-around, forward during pop) and randomized traffic, all compared
// against a queue-based model of the buffer.
module tb_store_buffer;
  import mem_pkg::*;

  localparam int unsigned Depth = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(Depth)) u_if ();

  store_buffer #(
    .DEPTH  (Depth),
    .ADDR_W (15),
    .DATA_W (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  int errors = 0;
  int checks = 0;

  // Model: oldest store at index 0.
  sb_entry_t model_q[$];

  typedef struct {
    logic        rst;
    logic        ev;
    logic [14:0] a;
    logic [15:0] d;
    logic        mr;
    logic [14:0] f0;
    logic [14:0] f1;
    logic [3:0]  cnt;
    logic        rdy;
    logic        wen;
    logic [14:0] wa;
    logic [15:0] wd;
    logic        h0;
    logic [15:0] d0;
    logic        h1;
    logic [15:0] d1;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ev, input logic [14:0] a, input logic [15:0] d,
                       input logic mr, input logic [14:0] f0, input logic [14:0] f1);
    rst_n            = r;
    u_if.enq_valid   = ev;
    u_if.enq_addr    = a;
    u_if.enq_data    = d;
    u_if.mem_ready   = mr;
    u_if.fwd_addr0   = f0;
    u_if.fwd_addr1   = f1;
  endtask

  function automatic void fwd_model(input logic [14:0] a, output logic hit,
                                    output logic [15:0] data);
    hit  = 1'b0;
    data = '0;
    foreach (model_q[i]) begin
      if (model_q[i].addr == a) begin
        hit  = 1'b1;
        data = model_q[i].data;
      end
    end
  endfunction

  // Compare every output with the model; call away from the rising edge.
  task automatic sample();
    int          n;
    logic        h0, h1;
    logic [15:0] d0, d1;
    n = model_q.size();
    fwd_model(u_if.fwd_addr0, h0, d0);
    fwd_model(u_if.fwd_addr1, h1, d1);
    check("count",     32'(u_if.count),     32'(n));
    check("enq_ready", 32'(u_if.enq_ready), 32'(n != Depth));
    check("wen0",      32'(u_if.wen0),      32'(n != 0 && u_if.mem_ready));
    check("waddr0",    32'(u_if.waddr0),    (n != 0) ? 32'(model_q[0].addr) : 32'd0);
    check("wdata0",    32'(u_if.wdata0),    (n != 0) ? 32'(model_q[0].data) : 32'd0);
    check("fwd_hit0",  32'(u_if.fwd_hit0),  32'(h0));
    check("fwd_data0", 32'(u_if.fwd_data0), 32'(d0));
    check("fwd_hit1",  32'(u_if.fwd_hit1),  32'(h1));
    check("fwd_data1", 32'(u_if.fwd_data1), 32'(d1));
  endtask

  // Advance one clock and apply the same transaction to the model.
  task automatic commit();
    bit pop, push;
    @(posedge clk);
    if (!rst_n) begin
      model_q.delete();
    end else begin
      pop  = (model_q.size() != 0) && u_if.mem_ready;
      push = u_if.enq_valid && (model_q.size() != Depth);
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back('{addr: u_if.enq_addr, data: u_if.enq_data});
    end
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    commit();
  endtask

  function automatic vec_t mk(input logic r, input logic ev, input logic [14:0] a,
                              input logic [15:0] d, input logic mr, input logic [14:0] f0,
                              input logic [14:0] f1, input logic [3:0] cnt, input logic rdy,
                              input logic wen, input logic [14:0] wa, input logic [15:0] wd,
                              input logic h0, input logic [15:0] d0, input logic h1,
                              input logic [15:0] d1);
    vec_t v;
    v = '{r, ev, a, d, mr, f0, f1, cnt, rdy, wen, wa, wd, h0, d0, h1, d1};
    return v;
  endfunction

  initial begin
    // Reset (with a store offered), single drain, youngest-wins, reset mid-drain.
    vecs[0]  = mk(0, 1, 'h5,   'h55,   1, 'h5,   'h0,   0, 1, 0, 0,     0,      0, 0,      0, 0);
    vecs[1]  = mk(1, 0, 'h0,   'h0,    1, 'h5,   'h0,   0, 1, 0, 0,     0,      0, 0,      0, 0);
    vecs[2]  = mk(1, 1, 'h40,  'hBEEF, 1, 'h40,  'h41,  0, 1, 0, 0,     0,      0, 0,      0, 0);
    vecs[3]  = mk(1, 0, 'h0,   'h0,    1, 'h40,  'h41,  1, 1, 1, 'h40,  'hBEEF, 1, 'hBEEF, 0, 0);
    vecs[4]  = mk(1, 0, 'h0,   'h0,    1, 'h40,  'h41,  0, 1, 0, 0,     0,      0, 0,      0, 0);
    vecs[5]  = mk(1, 1, 'h100, 'h1111, 0, 'h100, 'h101, 0, 1, 0, 0,     0,      0, 0,      0, 0);
    vecs[6]  = mk(1, 1, 'h100, 'h2222, 0, 'h100, 'h101, 1, 1, 0, 'h100, 'h1111, 1, 'h1111, 0, 0);
    vecs[7]  = mk(1, 0, 'h0,   'h0,    0, 'h100, 'h101, 2, 1, 0, 'h100, 'h1111, 1, 'h2222, 0, 0);
    vecs[8]  = mk(1, 0, 'h0,   'h0,    1, 'h100, 'h101, 2, 1, 1, 'h100, 'h1111, 1, 'h2222, 0, 0);
    vecs[9]  = mk(1, 0, 'h0,   'h0,    1, 'h100, 'h101, 1, 1, 1, 'h100, 'h2222, 1, 'h2222, 0, 0);
    vecs[10] = mk(1, 0, 'h0,   'h0,    0, 'h100, 'h101, 0, 1, 0, 0,     0,      0, 0,      0, 0);
    vecs[11] = mk(1, 1, 'h7,   'h7777, 0, 'h7,   'h100, 0, 1, 0, 0,     0,      0, 0,      0, 0);
    vecs[12] = mk(0, 0, 'h0,   'h0,    1, 'h7,   'h100, 1, 1, 1, 'h7,   'h7777, 1, 'h7777, 0, 0);
    vecs[13] = mk(1, 0, 'h0,   'h0,    1, 'h7,   'h100, 0, 1, 0, 0,     0,      0, 0,      0, 0);

    // First reset edge: DUT state is unknown before it, so nothing is compared.
    drive(0, 1, 'h5, 'h55, 1, 'h5, 'h0);
    commit();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ev, vecs[i].a, vecs[i].d, vecs[i].mr, vecs[i].f0, vecs[i].f1);
      @(negedge clk);
      check($sformatf("vec%0d count", i),     32'(u_if.count),     32'(vecs[i].cnt));
      check($sformatf("vec%0d enq_ready", i), 32'(u_if.enq_ready), 32'(vecs[i].rdy));
      check($sformatf("vec%0d wen0", i),      32'(u_if.wen0),      32'(vecs[i].wen));
      check($sformatf("vec%0d waddr0", i),    32'(u_if.waddr0),    32'(vecs[i].wa));
      check($sformatf("vec%0d wdata0", i),    32'(u_if.wdata0),    32'(vecs[i].wd));
      check($sformatf("vec%0d fwd_hit0", i),  32'(u_if.fwd_hit0),  32'(vecs[i].h0));
      check($sformatf("vec%0d fwd_data0", i), 32'(u_if.fwd_data0), 32'(vecs[i].d0));
      check($sformatf("vec%0d fwd_hit1", i),  32'(u_if.fwd_hit1),  32'(vecs[i].h1));
      check($sformatf("vec%0d fwd_data1", i), 32'(u_if.fwd_data1), 32'(vecs[i].d1));
      sample();
      commit();
    end

    // Fill to full with the memory stalled.
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 15'('h10 + i), 16'('hA000 + i), 0, 'h10, 'h17);
      cycle();
    end
    drive(1, 1, 'h99, 'h9999, 0, 'h99, 'h10);
    @(negedge clk);
    sample();
    check("full count", 32'(u_if.count), 32'd8);
    check("full enq_ready", 32'(u_if.enq_ready), 32'd0);
    commit();
    // Pop cycle while full: enqueue still refused.
    drive(1, 1, 'h99, 'h9999, 1, 'h99, 'h17);
    @(negedge clk);
    sample();
    check("full-pop enq_ready", 32'(u_if.enq_ready), 32'd0);
    check("full-pop wen0", 32'(u_if.wen0), 32'd1);
    check("full-pop waddr0", 32'(u_if.waddr0), 32'h10);
    check("full-pop fwd_data1", 32'(u_if.fwd_data1), 32'hA007);
    commit();
    drive(1, 0, 'h0, 'h0, 0, 'h99, 'h10);
    @(negedge clk);
    sample();
    check("after full-pop count", 32'(u_if.count), 32'd7);
    check("after full-pop fwd_hit0", 32'(u_if.fwd_hit0), 32'd0);
    commit();
    for (int i = 1; i < 8; i++) begin
      drive(1, 0, 'h0, 'h0, 1, 'h99, 'h0);
      @(negedge clk);
      sample();
      check($sformatf("drain order %0d", i), 32'(u_if.waddr0), 32'('h10 + i));
      commit();
    end

    // Wrap-around: alternate enq/pop so the pointers advance past the end, then leave three
    // live entries straddling the last slot and slot 0 with a duplicate address.
    for (int i = 0; i < 14; i++) begin
      drive(1, 1, 15'('h180 + i), 16'('hC000 + i), 0, 'h180, 'h200);
      cycle();
      drive(1, 0, 'h0, 'h0, 1, 'h180, 'h200);
      cycle();
    end
    drive(1, 1, 'h1FF, 'h1234, 0, 'h200, 'h1FF);
    cycle();
    drive(1, 1, 'h200, 'hAAAA, 0, 'h200, 'h1FF);
    cycle();
    drive(1, 1, 'h200, 'hBBBB, 0, 'h200, 'h1FF);
    cycle();
    drive(1, 0, 'h0, 'h0, 0, 'h200, 'h1FF);
    @(negedge clk);
    sample();
    check("wrap count", 32'(u_if.count), 32'd3);
    check("wrap fwd_data0", 32'(u_if.fwd_data0), 32'hBBBB);
    check("wrap fwd_data1", 32'(u_if.fwd_data1), 32'h1234);
    commit();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 'h0, 'h0, 1, 'h200, 'h1FF);
      cycle();
    end

    // Forward during pop, and a same-cycle enqueue that is not yet forwardable.
    drive(1, 1, 'h300, 'h5555, 0, 'h300, 'h301);
    cycle();
    drive(1, 1, 'h301, 'h6666, 1, 'h300, 'h301);
    @(negedge clk);
    sample();
    check("pop-cycle fwd_hit0", 32'(u_if.fwd_hit0), 32'd1);
    check("pop-cycle fwd_data0", 32'(u_if.fwd_data0), 32'h5555);
    check("same-cycle enq fwd_hit1", 32'(u_if.fwd_hit1), 32'd0);
    commit();
    drive(1, 0, 'h0, 'h0, 0, 'h300, 'h301);
    @(negedge clk);
    sample();
    check("after pop fwd_hit0", 32'(u_if.fwd_hit0), 32'd0);
    check("next cycle fwd_hit1", 32'(u_if.fwd_hit1), 32'd1);
    check("next cycle fwd_data1", 32'(u_if.fwd_data1), 32'h6666);
    commit();
    drive(1, 0, 'h0, 'h0, 1, 'h300, 'h301);
    cycle();

    // Randomized traffic; the drain probability changes in phases to reach full and empty.
    begin
      int unsigned mr_pct;
      mr_pct = 50;
      for (int i = 0; i < 600; i++) begin
        if (i % 40 == 0) mr_pct = $urandom_range(100);
        drive(($urandom_range(79) != 0),
              ($urandom_range(3) != 0),
              15'('h0A00 | $urandom_range(7)),
              16'($urandom),
              ($urandom_range(99) < mr_pct),
              15'('h0A00 | $urandom_range(7)),
              15'('h0A00 | $urandom_range(7)));
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
